// File: rtl/branch_hazard_ctrl.sv
// ============================================================================
// branch_hazard_ctrl
// ID-stage branch hazard sequencer: stalls for unforwardable operands, then
// resolves the branch and keeps saturating taken/stall statistics.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_hazard_ctrl #(
  parameter int CNT_W          = 16,
  parameter bit FLUSH_ON_TAKEN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_branch,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             mem_memread,
  input  logic [4:0]       mem_rd,
  input  logic             meet,
  input  logic             hold,
  input  logic             kill,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             pc_sel_branch,
  output logic             busy,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STALL   = 2'd1,
    S_RESOLVE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       stall_left_q, stall_left_d;
  logic [CNT_W-1:0] taken_q, taken_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic       valid_br_w;
  logic       use_rt_w;
  logic       ex_hit_w;
  logic       mem_hit_w;
  logic [1:0] need_w;

  logic pc_stall_w, ifid_stall_w, bubble_w, flush_w, sel_w;

  always_comb begin
    case (id_branch)
      4'b0001, 4'b0011, 4'b0101, 4'b0111, 4'b1001, 4'b1011: valid_br_w = 1'b1;
      default:                                              valid_br_w = 1'b0;
    endcase
  end

  assign use_rt_w  = (id_branch == 4'b0001) || (id_branch == 4'b0011);

  // Register 0 is hardwired, so a zero source never waits on anything.
  assign ex_hit_w  = ((id_rs != 5'd0) && (ex_rd == id_rs)) ||
                     (use_rt_w && (id_rt != 5'd0) && (ex_rd == id_rt));
  assign mem_hit_w = ((id_rs != 5'd0) && (mem_rd == id_rs)) ||
                     (use_rt_w && (id_rt != 5'd0) && (mem_rd == id_rt));

  always_comb begin
    if (ex_memread && ex_hit_w)
      need_w = 2'd2;
    else if ((ex_regwrite && ex_hit_w) || (mem_memread && mem_hit_w))
      need_w = 2'd1;
    else
      need_w = 2'd0;
  end

  always_comb begin
    state_d      = state_q;
    stall_left_d = stall_left_q;
    taken_d      = taken_q;
    stall_d      = stall_q;
    pc_stall_w   = 1'b0;
    ifid_stall_w = 1'b0;
    bubble_w     = 1'b0;
    flush_w      = 1'b0;
    sel_w        = 1'b0;

    if (kill) begin
      // Abort wins over freeze, but a concurrent memory wait still holds the front end.
      state_d      = S_IDLE;
      stall_left_d = 2'd0;
      pc_stall_w   = hold;
      ifid_stall_w = hold;
    end else if (hold) begin
      pc_stall_w   = 1'b1;
      ifid_stall_w = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_br_w) begin
            if (need_w == 2'd0) begin
              sel_w   = meet;
              flush_w = meet & FLUSH_ON_TAKEN;
            end else begin
              stall_left_d = need_w;
              state_d      = S_STALL;
              pc_stall_w   = 1'b1;
              ifid_stall_w = 1'b1;
              bubble_w     = 1'b1;
            end
          end
        end
        S_STALL: begin
          pc_stall_w   = 1'b1;
          ifid_stall_w = 1'b1;
          bubble_w     = 1'b1;
          stall_left_d = stall_left_q - 2'd1;
          stall_d      = (&stall_q) ? stall_q : stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (stall_left_q <= 2'd1)
            state_d = S_RESOLVE;
        end
        S_RESOLVE: begin
          sel_w   = meet;
          flush_w = meet & FLUSH_ON_TAKEN;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (sel_w && !(&taken_q))
      taken_d = taken_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      stall_left_q <= 2'd0;
      taken_q      <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      stall_left_q <= stall_left_d;
      taken_q      <= taken_d;
      stall_q      <= stall_d;
    end
  end

  // Outputs are forced quiet while reset is asserted so no redirect escapes.
  assign pc_stall      = pc_stall_w   & ~rst;
  assign ifid_stall    = ifid_stall_w & ~rst;
  assign idex_bubble   = bubble_w     & ~rst;
  assign ifid_flush    = flush_w      & ~rst;
  assign pc_sel_branch = sel_w        & ~rst;
  assign busy          = (state_q != S_IDLE) & ~rst;
  assign taken_cnt     = taken_q;
  assign stall_cnt     = stall_q;

endmodule

`default_nettype wire
